ps2_kbd_tx: RTL and testbench

//   PS/2 keyboard-side transmitter: turns key events (scan code + make/break)

---
 rtl/ps2_kbd_tx.sv | 188 ++++++++++++++++++
 tb/tb_ps2_kbd_tx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard-side transmitter: sends key events as device-to-host frames.
// Each event is sent as [E0 if extended][F0 if break] code. Every byte is an
// 11-bit frame, followed by an idle gap with both lines high.
// Optional feature macro: PS2_TX_EXT_EN enables the E0 prefix for in_ext=1.
// When the macro is not defined, in_ext is ignored.
module ps2_kbd_tx #(
  parameter int CLK_HALF = 2000,
  parameter int GAP_CYC  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_code,
  input  logic       in_break,
  input  logic       in_ext,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic [7:0] event_count
);

  localparam int HW = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [HW-1:0] HMAX = HW'(CLK_HALF - 1);
  localparam logic [GW-1:0] GMAX = GW'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t        state, state_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic [3:0]    bcnt, bcnt_n;
  logic          phase_lo, phase_lo_n;
  logic [10:0]   frame, frame_n;
  logic [15:0]   pend, pend_n;
  logic [1:0]    npend, npend_n;
  logic          clk_n, data_n;
  logic [7:0]    evcnt_n;
  logic          accept;
  logic [7:0]    first_b;
  logic [15:0]   rest_b;
  logic [1:0]    rest_n;

  // Frame bits LSB first: start 0, data LSB..MSB, odd parity, stop 1.
  function automatic logic [10:0] mk_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  assign in_ready = (state == IDLE) & ~rst;
  assign busy     = (state != IDLE);
  assign accept   = in_valid & in_ready;

`ifndef PS2_TX_EXT_EN
  logic unused_ext;
  assign unused_ext = in_ext;
`endif

  // Split the event into the first byte plus the queue of bytes that follow it.
  always_comb begin
    first_b = in_code;
    rest_b  = '0;
    rest_n  = '0;
`ifdef PS2_TX_EXT_EN
    if (in_ext && in_break) begin
      first_b = 8'hE0;
      rest_b  = {in_code, 8'hF0};
      rest_n  = 2'd2;
    end else if (in_ext) begin
      first_b = 8'hE0;
      rest_b  = {8'h00, in_code};
      rest_n  = 2'd1;
    end else if (in_break) begin
      first_b = 8'hF0;
      rest_b  = {8'h00, in_code};
      rest_n  = 2'd1;
    end
`else
    if (in_break) begin
      first_b = 8'hF0;
      rest_b  = {8'h00, in_code};
      rest_n  = 2'd1;
    end
`endif
  end

  // Next-state logic: bit timing, frame shifting, gap timing and event count.
  // The line outputs are computed here one cycle ahead so they can be registered.
  always_comb begin
    state_n    = state;
    hcnt_n     = hcnt;
    gcnt_n     = gcnt;
    bcnt_n     = bcnt;
    phase_lo_n = phase_lo;
    frame_n    = frame;
    pend_n     = pend;
    npend_n    = npend;
    clk_n      = ps2_clk;
    data_n     = ps2_data;
    evcnt_n    = event_count;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n    = SHIFT;
          frame_n    = mk_frame(first_b);
          data_n     = 1'b0;
          clk_n      = 1'b1;
          hcnt_n     = '0;
          bcnt_n     = '0;
          phase_lo_n = 1'b0;
          pend_n     = rest_b;
          npend_n    = rest_n;
        end
      end
      SHIFT: begin
        hcnt_n = hcnt + 1'b1;
        if (hcnt == HMAX) begin
          hcnt_n = '0;
          if (!phase_lo) begin
            phase_lo_n = 1'b1;
            clk_n      = 1'b0;
          end else begin
            phase_lo_n = 1'b0;
            clk_n      = 1'b1;
            if (bcnt == 4'd10) begin
              state_n = GAP;
              gcnt_n  = '0;
              data_n  = 1'b1;
            end else begin
              bcnt_n  = bcnt + 4'd1;
              frame_n = {1'b1, frame[10:1]};
              data_n  = frame[1];
            end
          end
        end
      end
      GAP: begin
        gcnt_n = gcnt + 1'b1;
        if (gcnt == GMAX) begin
          if (npend != 2'd0) begin
            state_n    = SHIFT;
            frame_n    = mk_frame(pend[7:0]);
            data_n     = 1'b0;
            pend_n     = {8'h00, pend[15:8]};
            npend_n    = npend - 2'd1;
            hcnt_n     = '0;
            bcnt_n     = '0;
            phase_lo_n = 1'b0;
          end else begin
            state_n = IDLE;
            evcnt_n = event_count + 8'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset abandons any event in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hcnt        <= '0;
      gcnt        <= '0;
      bcnt        <= '0;
      phase_lo    <= 1'b0;
      frame       <= '1;
      pend        <= '0;
      npend       <= '0;
      ps2_clk     <= 1'b1;
      ps2_data    <= 1'b1;
      event_count <= '0;
    end else begin
      state       <= state_n;
      hcnt        <= hcnt_n;
      gcnt        <= gcnt_n;
      bcnt        <= bcnt_n;
      phase_lo    <= phase_lo_n;
      frame       <= frame_n;
      pend        <= pend_n;
      npend       <= npend_n;
      ps2_clk     <= clk_n;
      ps2_data    <= data_n;
      event_count <= evcnt_n;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Testbench for ps2_kbd_tx with CLK_HALF=4, GAP_CYC=8. Captures ps2_data at
// every ps2_clk falling edge and compares against frames built from the byte
// sequence of each event.
module tb_ps2_kbd_tx;
  localparam int H = 4;
  localparam int G = 8;
  localparam int FRAME_CYC = 22 * H + G;
  localparam int LIM = 2000;
`ifdef PS2_TX_EXT_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_break = 1'b0;
  logic in_ext = 1'b0;
  logic [7:0] in_code = 8'h00;
  logic in_ready, ps2_clk, ps2_data, busy;
  logic [7:0] event_count;

  int nassert = 0;
  int nfail = 0;
  int glitches = 0;
  bit cap_q[$];
  bit exp_q[$];
  logic prev_clk = 1'b1;
  logic prev_data = 1'b1;
  logic [7:0] exp_count = 8'h00;

  always #5 clk = ~clk;

  ps2_kbd_tx #(.CLK_HALF(H), .GAP_CYC(G)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_break(in_break), .in_ext(in_ext),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data), .busy(busy),
    .event_count(event_count)
  );

  // Host-side sampler: data taken at each ps2_clk fall; data must not move while low.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_clk === 1'b1 && ps2_clk === 1'b0) cap_q.push_back(ps2_data);
      if (prev_clk === 1'b0 && ps2_clk === 1'b0 && ps2_data !== prev_data) glitches++;
    end
    prev_clk = ps2_clk;
    prev_data = ps2_data;
  end

  function automatic void add_byte(input logic [7:0] b);
    int ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(b[i]);
      ones += int'(b[i]);
    end
    exp_q.push_back(ones % 2 == 0);
    exp_q.push_back(1'b1);
  endfunction

  function automatic int build_exp(input logic [7:0] c, input bit b, input bit e);
    int n = 1;
    exp_q.delete();
    if (e && EXT_EN) begin add_byte(8'hE0); n++; end
    if (b) begin add_byte(8'hF0); n++; end
    add_byte(c);
    return n;
  endfunction

  function automatic bit bits_match();
    if (cap_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) if (cap_q[i] != exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Offer one event, then count cycles from the accept edge until in_ready returns.
  task automatic do_event(input logic [7:0] c, input bit b, input bit e,
                          output int lat, output bit hs_ok);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < LIM) begin @(negedge clk); n++; end
    in_code = c; in_break = b; in_ext = e; in_valid = 1'b1;
    @(posedge clk);
    cap_q.delete();
    #1;
    in_valid = 1'b0;
    in_code = 8'($urandom);
    in_break = 1'($urandom);
    in_ext = 1'($urandom);
    hs_ok = (in_ready === 1'b0) && (busy === 1'b1);
    lat = 0;
    while (lat < LIM) begin
      @(posedge clk); lat++; #1;
      if (in_ready === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nassert++;
    if (in_ready !== 1'b0 || ps2_clk !== 1'b1 || ps2_data !== 1'b1 || event_count !== 8'h00 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL reset_hold: ready=%b clk=%b data=%b cnt=%0d busy=%b, want 0 1 1 0 0",
               in_ready, ps2_clk, ps2_data, event_count, busy);
    end
    rst = 1'b0;
    #1;
    nassert++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL reset_release: ready=%b busy=%b, want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0, lat;
    bit hs;
    int nb;
    @(negedge clk);
    in_code = 8'h55; in_break = 1'b0; in_ext = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    cap_q.delete();
    #1 in_valid = 1'b0;
    while (cap_q.size() < 5 && n < LIM) begin @(negedge clk); n++; end
    nassert++;
    if (cap_q.size() < 5) begin
      nfail++;
      $display("FAIL midrst_reach: falls=%0d, want 5", cap_q.size());
    end
    rst = 1'b1;
    @(posedge clk); #1;
    nassert++;
    if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || in_ready !== 1'b0) begin
      nfail++;
      $display("FAIL midrst_lines: clk=%b data=%b ready=%b, want 1 1 0", ps2_clk, ps2_data, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    nassert++;
    if (in_ready !== 1'b1 || event_count !== exp_count || busy !== 1'b0) begin
      nfail++;
      $display("FAIL midrst_after: ready=%b cnt=%0d busy=%b, want 1 %0d 0", in_ready, event_count, busy, exp_count);
    end
    nb = build_exp(8'h45, 1'b0, 1'b0);
    do_event(8'h45, 1'b0, 1'b0, lat, hs);
    exp_count = exp_count + 8'd1;
    nassert++;
    if (!bits_match() || lat != nb * FRAME_CYC || event_count !== exp_count) begin
      nfail++;
      $display("FAIL midrst_next: falls=%0d lat=%0d cnt=%0d, want %0d %0d %0d",
               cap_q.size(), lat, event_count, exp_q.size(), nb * FRAME_CYC, exp_count);
    end
  endtask

  task automatic test_directed();
    logic [7:0] codes[3] = '{8'h1C, 8'h1C, 8'h74};
    bit brks[3] = '{1'b0, 1'b1, 1'b1};
    bit exts[3] = '{1'b0, 1'b0, 1'b1};
    int nb, lat;
    bit hs;
    for (int k = 0; k < 3; k++) begin
      nb = build_exp(codes[k], brks[k], exts[k]);
      do_event(codes[k], brks[k], exts[k], lat, hs);
      exp_count = exp_count + 8'd1;
      nassert++;
      if (!hs) begin nfail++; $display("FAIL dir_handshake[%0d]: ready/busy after accept wrong, want 0/1", k); end
      nassert++;
      if (lat != nb * FRAME_CYC) begin
        nfail++; $display("FAIL dir_latency[%0d]: got %0d cycles, want %0d", k, lat, nb * FRAME_CYC);
      end
      nassert++;
      if (!bits_match()) begin
        nfail++; $display("FAIL dir_bits[%0d]: %0d falls captured, want %0d falls with matching bits", k, cap_q.size(), exp_q.size());
      end
      nassert++;
      if (event_count !== exp_count || busy !== 1'b0) begin
        nfail++; $display("FAIL dir_count[%0d]: cnt=%0d busy=%b, want %0d 0", k, event_count, busy, exp_count);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] c;
    bit b, e, hs;
    int nb, lat;
    for (int k = 0; k < 12; k++) begin
      c = 8'($urandom);
      b = 1'($urandom);
      e = 1'($urandom);
      nb = build_exp(c, b, e);
      do_event(c, b, e, lat, hs);
      exp_count = exp_count + 8'd1;
      nassert++;
      if (!hs || lat != nb * FRAME_CYC) begin
        nfail++; $display("FAIL rnd_timing[%0d]: hs=%b lat=%0d, want 1 %0d", k, hs, lat, nb * FRAME_CYC);
      end
      nassert++;
      if (!bits_match()) begin
        nfail++; $display("FAIL rnd_bits[%0d] code=%h brk=%b ext=%b: %0d falls, want %0d matching", k, c, b, e, cap_q.size(), exp_q.size());
      end
      nassert++;
      if (event_count !== exp_count) begin
        nfail++; $display("FAIL rnd_count[%0d]: got %0d, want %0d", k, event_count, exp_count);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n, bad = 0;
    logic [7:0] base = exp_count;
    logic [7:0] byte_v;
    int ones;
    @(negedge clk);
    in_code = 8'h16; in_break = 1'b0; in_ext = 1'b0; in_valid = 1'b1;
    cap_q.delete();
    for (int k = 0; k < 256; k++) begin
      n = 0;
      while (!in_ready && n < LIM) begin @(negedge clk); n++; end
      nassert++;
      if (!in_ready || event_count !== exp_count) begin
        nfail++;
        $display("FAIL b2b_count[%0d]: ready=%b cnt=%0d, want 1 %0d", k, in_ready, event_count, exp_count);
        if (!in_ready) break;
      end
      @(posedge clk);
      exp_count = exp_count + 8'd1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n = 0;
    while (!in_ready && n < LIM) begin @(negedge clk); n++; end
    nassert++;
    if (event_count !== exp_count || exp_count !== base) begin
      nfail++; $display("FAIL b2b_wrap: cnt=%0d, want %0d", event_count, base);
    end
    for (int f = 0; f + 11 <= cap_q.size(); f += 11) begin
      byte_v = 8'h00; ones = 0;
      for (int i = 0; i < 8; i++) begin
        byte_v[i] = cap_q[f + 1 + i];
        ones += int'(cap_q[f + 1 + i]);
      end
      if (cap_q[f] != 1'b0 || byte_v != 8'h16 || (ones + int'(cap_q[f + 9])) % 2 != 1 || cap_q[f + 10] != 1'b1) bad++;
    end
    nassert++;
    if (cap_q.size() != 256 * 11 || bad != 0) begin
      nfail++; $display("FAIL b2b_decode: falls=%0d bad_frames=%0d, want %0d 0", cap_q.size(), bad, 256 * 11);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_directed();
    test_random();
    test_back_to_back();
    nassert++;
    if (glitches != 0) begin
      nfail++; $display("FAIL data_stable: %0d data changes while ps2_clk low, want 0", glitches);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
